// File: rtl/gf_pkg.sv
// Shared types and sizes for the polygon summary pipeline.
// Coordinate, area and box widths plus the collector state encoding.
package gf_pkg;

    localparam int FRAME_LEN = 6;
    localparam int COORD_W   = 10;
    localparam int AREA_W    = 25;
    localparam int BOX_W     = 20;
    localparam int CNT_W     = 3;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_COLLECT = 1'b1
    } col_state_t;

    typedef struct packed {
        logic [COORD_W-1:0] min_x;
        logic [COORD_W-1:0] max_x;
        logic [COORD_W-1:0] min_y;
        logic [COORD_W-1:0] max_y;
        logic [AREA_W-1:0]  area;
        logic               err;
    } bbox_t;

endpackage

// File: rtl/poly_bbox_acc.sv
// Running min/max and area-mismatch accumulator for one frame.
// The merged output already includes the beat presented this cycle.
import gf_pkg::*;

module poly_bbox_acc (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               update,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic [AREA_W-1:0]  area,
    output bbox_t              merged
);

    bbox_t acc;

    always_comb begin
        merged = acc;
        if (load) begin
            merged.min_x = x;
            merged.max_x = x;
            merged.min_y = y;
            merged.max_y = y;
            merged.area  = area;
            merged.err   = 1'b0;
        end else if (update) begin
            if (x < acc.min_x) merged.min_x = x;
            if (x > acc.max_x) merged.max_x = x;
            if (y < acc.min_y) merged.min_y = y;
            if (y > acc.max_y) merged.max_y = y;
            merged.err = acc.err | (area != acc.area);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else if (load || update) begin
            acc <= merged;
        end
    end

endmodule

// File: rtl/poly_summary.sv
// Collects FRAME_LEN vertex beats into a bounding-box summary,
// then a stage-1 register and a held output register with drop flag.
import gf_pkg::*;

module poly_summary (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [COORD_W-1:0] in_x,
    input  logic [COORD_W-1:0] in_y,
    input  logic [AREA_W-1:0]  in_area,
    input  logic               out_ready,
    output logic               out_valid,
    output logic [COORD_W-1:0] out_min_x,
    output logic [COORD_W-1:0] out_max_x,
    output logic [COORD_W-1:0] out_min_y,
    output logic [COORD_W-1:0] out_max_y,
    output logic [BOX_W-1:0]   out_box_area,
    output logic [AREA_W-1:0]  out_poly_area,
    output logic               out_fill_ok,
    output logic               out_err,
    output logic               ovf
);

    col_state_t       state;
    logic [CNT_W-1:0] count;
    bbox_t            merged;
    bbox_t            s1;
    logic             s1_valid;
    logic             beat_load;
    logic             beat_upd;
    logic             final_beat;

    // rst_n is active-high here: asserted means reset.
    assign beat_load  = !rst_n && in_valid && (state == ST_IDLE);
    assign beat_upd   = !rst_n && in_valid && (state == ST_COLLECT);
    assign final_beat = beat_upd && (count == CNT_W'(FRAME_LEN - 1));

    poly_bbox_acc u_acc (
        .clk    (clk),
        .rst    (rst_n),
        .load   (beat_load),
        .update (beat_upd),
        .x      (in_x),
        .y      (in_y),
        .area   (in_area),
        .merged (merged)
    );

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state <= ST_IDLE;
            count <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        state <= ST_COLLECT;
                        count <= CNT_W'(1);
                    end
                end
                ST_COLLECT: begin
                    if (!in_valid || final_beat) begin
                        state <= ST_IDLE;
                        count <= '0;
                    end else begin
                        count <= count + CNT_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    count <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            s1       <= '0;
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= final_beat;
            if (final_beat) s1 <= merged;
        end
    end

    logic [COORD_W-1:0] dx;
    logic [COORD_W-1:0] dy;
    logic [BOX_W-1:0]   box;
    logic [AREA_W:0]    twice;
    logic               fill;

    assign dx    = s1.max_x - s1.min_x;
    assign dy    = s1.max_y - s1.min_y;
    assign box   = BOX_W'(dx) * BOX_W'(dy);
    assign twice = {s1.area, 1'b0};
    assign fill  = twice >= (AREA_W + 1)'(box);

    // A held, unaccepted summary wins; the newcomer is dropped.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            out_valid     <= 1'b0;
            out_min_x     <= '0;
            out_max_x     <= '0;
            out_min_y     <= '0;
            out_max_y     <= '0;
            out_box_area  <= '0;
            out_poly_area <= '0;
            out_fill_ok   <= 1'b0;
            out_err       <= 1'b0;
            ovf           <= 1'b0;
        end else if (s1_valid) begin
            if (!out_valid || out_ready) begin
                out_valid     <= 1'b1;
                out_min_x     <= s1.min_x;
                out_max_x     <= s1.max_x;
                out_min_y     <= s1.min_y;
                out_max_y     <= s1.max_y;
                out_box_area  <= box;
                out_poly_area <= s1.area;
                out_fill_ok   <= fill;
                out_err       <= s1.err;
            end else begin
                ovf <= 1'b1;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_poly_summary.sv
// Randomized scoreboard bench for poly_summary with a frame-level
// reference model built from beat queues and plain arithmetic.
module tb_poly_summary;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [9:0]  in_x;
    logic [9:0]  in_y;
    logic [24:0] in_area;
    logic        out_ready;
    logic        out_valid;
    logic [9:0]  out_min_x;
    logic [9:0]  out_max_x;
    logic [9:0]  out_min_y;
    logic [9:0]  out_max_y;
    logic [19:0] out_box_area;
    logic [24:0] out_poly_area;
    logic        out_fill_ok;
    logic        out_err;
    logic        ovf;

    poly_summary dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_x          (in_x),
        .in_y          (in_y),
        .in_area       (in_area),
        .out_ready     (out_ready),
        .out_valid     (out_valid),
        .out_min_x     (out_min_x),
        .out_max_x     (out_max_x),
        .out_min_y     (out_min_y),
        .out_max_y     (out_max_y),
        .out_box_area  (out_box_area),
        .out_poly_area (out_poly_area),
        .out_fill_ok   (out_fill_ok),
        .out_err       (out_err),
        .ovf           (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        int mnx;
        int mxx;
        int mny;
        int mxy;
        int box;
        int area;
        bit fill;
        bit err;
    } sum_t;

    sum_t sbq[$];
    int   checks = 0;
    int   failures = 0;

    // Reference model state
    int   fx[$];
    int   fy[$];
    int   fa[$];
    bit   pend;
    sum_t pv;
    bit   slot;
    bit   m_ovf;

    function automatic sum_t summarize();
        sum_t s;
        s.mnx = fx[0]; s.mxx = fx[0];
        s.mny = fy[0]; s.mxy = fy[0];
        s.area = fa[0];
        s.err = 1'b0;
        foreach (fx[i]) begin
            if (fx[i] < s.mnx) s.mnx = fx[i];
            if (fx[i] > s.mxx) s.mxx = fx[i];
            if (fy[i] < s.mny) s.mny = fy[i];
            if (fy[i] > s.mxy) s.mxy = fy[i];
            if (fa[i] != fa[0]) s.err = 1'b1;
        end
        s.box = (s.mxx - s.mnx) * (s.mxy - s.mny);
        s.fill = (longint'(s.area) * 2) >= longint'(s.box);
        return s;
    endfunction

    task automatic model_step();
        if (rst_n) begin
            fx.delete(); fy.delete(); fa.delete();
            pend = 0; slot = 0; m_ovf = 0;
            sbq.delete();
        end else begin
            if (pend) begin
                if (slot && !out_ready) m_ovf = 1;
                else begin
                    sbq.push_back(pv);
                    slot = 1;
                end
            end else if (slot && out_ready) begin
                slot = 0;
            end
            pend = 0;
            if (in_valid) begin
                fx.push_back(int'(in_x));
                fy.push_back(int'(in_y));
                fa.push_back(int'(in_area));
                if (fx.size() == 6) begin
                    pv = summarize();
                    pend = 1;
                    fx.delete(); fy.delete(); fa.delete();
                end
            end else begin
                fx.delete(); fy.delete(); fa.delete();
            end
        end
    endtask

    initial begin
        pend = 0; slot = 0; m_ovf = 0;
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    initial begin
        sum_t e;
        sum_t g;
        forever begin
            @(negedge clk);
            checks++;
            if (out_valid !== slot) begin
                failures++;
                $display("FAIL valid got=%b exp=%b t=%0t",
                         out_valid, slot, $time);
            end
            checks++;
            if (ovf !== m_ovf) begin
                failures++;
                $display("FAIL ovf got=%b exp=%b t=%0t",
                         ovf, m_ovf, $time);
            end
            if (!rst_n && out_valid && out_ready) begin
                g.mnx = int'(out_min_x); g.mxx = int'(out_max_x);
                g.mny = int'(out_min_y); g.mxy = int'(out_max_y);
                g.box = int'(out_box_area);
                g.area = int'(out_poly_area);
                g.fill = out_fill_ok; g.err = out_err;
                checks++;
                if (sbq.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_out t=%0t", $time);
                end else begin
                    e = sbq.pop_front();
                    if (g != e) begin
                        failures++;
                        $display({"FAIL summary got=%0d/%0d/%0d/%0d",
                                  " box=%0d a=%0d f=%b e=%b exp=",
                                  "%0d/%0d/%0d/%0d box=%0d a=%0d",
                                  " f=%b e=%b t=%0t"},
                                 g.mnx, g.mxx, g.mny, g.mxy, g.box,
                                 g.area, g.fill, g.err, e.mnx, e.mxx,
                                 e.mny, e.mxy, e.box, e.area, e.fill,
                                 e.err, $time);
                    end
                end
            end
        end
    end

    int dxs[6] = '{10, 50, 30, 0, 70, 20};
    int dys[6] = '{20, 5, 90, 40, 60, 10};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(int x, int y, int a);
        in_valid = 1'b1;
        in_x = 10'(x);
        in_y = 10'(y);
        in_area = 25'(a);
        step();
    endtask

    task automatic idle(int n);
        in_valid = 1'b0;
        repeat (n) step();
    endtask

    task automatic send_frame(int a, int bad, int bad_a);
        for (int i = 0; i < 6; i++)
            send(dxs[i], dys[i], (i == bad) ? bad_a : a);
    endtask

    initial begin
        int n;
        int base;
        rst_n = 1'b1;
        in_valid = 1'b0;
        in_x = '0; in_y = '0; in_area = '0;
        out_ready = 1'b1;
        repeat (3) step();
        @(negedge clk);
        checks++;
        if (out_valid || ovf || out_min_x != 0 || out_max_x != 0 ||
            out_min_y != 0 || out_max_y != 0 || out_box_area != 0 ||
            out_poly_area != 0 || out_fill_ok || out_err) begin
            failures++;
            $display("FAIL reset got v=%b ovf=%b box=%0d a=%0d exp=0",
                     out_valid, ovf, out_box_area, out_poly_area);
        end
        @(posedge clk); #1;
        rst_n = 1'b0;
        idle(2);

        send_frame(3000, -1, 0);
        idle(4);
        send_frame(1000, -1, 0);
        idle(4);
        send_frame(3000, 3, 3001);
        idle(4);

        out_ready = 1'b0;
        send_frame(3000, -1, 0);
        send_frame(1000, -1, 0);
        idle(6);
        out_ready = 1'b1;
        idle(4);

        for (int i = 0; i < 4; i++) send(dxs[i], dys[i], 500);
        idle(2);
        send_frame(2500, -1, 0);
        idle(4);

        for (int i = 0; i < 3; i++) send(dxs[i], dys[i], 700);
        rst_n = 1'b1;
        send(dxs[3], dys[3], 700);
        rst_n = 1'b0;
        send_frame(4000, -1, 0);
        idle(4);

        for (int i = 0; i < 6; i++) send(512, 512, 0);
        idle(4);

        for (int f = 0; f < 60; f++) begin
            n = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 5) : 6;
            base = $urandom_range(0, 600000);
            for (int i = 0; i < n; i++) begin
                out_ready = ($urandom_range(0, 3) != 0);
                send($urandom_range(0, 1023), $urandom_range(0, 1023),
                     ($urandom_range(0, 9) == 0) ? base + 1 : base);
            end
            in_valid = 1'b0;
            for (int k = 0; k < $urandom_range((n < 6) ? 1 : 0, 3); k++) begin
                out_ready = ($urandom_range(0, 3) != 0);
                step();
            end
        end

        out_ready = 1'b1;
        idle(8);
        checks++;
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL drain got=%0d pending exp=0", sbq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
